// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_lsu
// Purpose  : Load/store unit between EX/MEM and a word-organised data memory.
//            Turns byte/halfword accesses into word accesses (read-modify-
//            write for sub-word stores), extends load results big-endian,
//            and flags misaligned or illegal operations.
// Revision : 1.0  initial release
// ============================================================================
module mem_lsu #(
  parameter int ADDR_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [2:0] OP_WORD = 3'b010;

  logic [2:0]  state;
  logic [2:0]  op_q;
  logic        store_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;

  logic        accept;
  logic        bad_req;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] ext_data;
  logic [31:0] merged;

  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid & req_ready;

  // Classify the incoming request: unknown codes, unsigned stores, misalignment
  always_comb begin
    bad_req = 1'b0;
    case (req_op)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: bad_req = 1'b0;
      default:                                bad_req = 1'b1;
    endcase
    if (req_store && req_op[2])
      bad_req = 1'b1;
    if ((req_op[1:0] == 2'b01) && req_addr[0])
      bad_req = 1'b1;
    if ((req_op[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))
      bad_req = 1'b1;
  end

  // Big-endian lane selection, load extension and sub-word store merge
  always_comb begin
    case (off_q)
      2'd0:    sel_byte = mem_rdata[31:24];
      2'd1:    sel_byte = mem_rdata[23:16];
      2'd2:    sel_byte = mem_rdata[15:8];
      default: sel_byte = mem_rdata[7:0];
    endcase
    sel_half = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];

    case (op_q[1:0])
      2'b00:   ext_data = op_q[2] ? {24'd0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      2'b01:   ext_data = op_q[2] ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
      default: ext_data = mem_rdata;
    endcase

    merged = mem_rdata;
    if (op_q[1:0] == 2'b00) begin
      case (off_q)
        2'd0:    merged[31:24] = wdata_q[7:0];
        2'd1:    merged[23:16] = wdata_q[7:0];
        2'd2:    merged[15:8]  = wdata_q[7:0];
        default: merged[7:0]   = wdata_q[7:0];
      endcase
    end else begin
      if (off_q[1])
        merged[15:0]  = wdata_q[15:0];
      else
        merged[31:16] = wdata_q[15:0];
    end
  end

  // Sequencer: strobes and completion flags are registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= 3'd0;
      store_q   <= 1'b0;
      off_q     <= 2'd0;
      wdata_q   <= 32'd0;
      mem_addr  <= 32'd0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_wdata <= 32'd0;
      done      <= 1'b0;
      load_data <= 32'd0;
      fault     <= 1'b0;
    end else begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q     <= req_op;
            store_q  <= req_store;
            off_q    <= req_addr[1:0];
            wdata_q  <= req_wdata;
            mem_addr <= req_addr >> ADDR_SHIFT;
            if (bad_req) begin
              // Faulted requests never touch memory
              state     <= S_DONE;
              done      <= 1'b1;
              fault     <= 1'b1;
              load_data <= 32'd0;
            end else if (req_store && (req_op == OP_WORD)) begin
              // Full-word store needs no read-back
              state     <= S_WR;
              mem_write <= 1'b1;
              mem_wdata <= req_wdata;
            end else begin
              state    <= S_RD;
              mem_read <= 1'b1;
            end
          end
        end
        S_RD: begin
          state <= S_CAP;
        end
        S_CAP: begin
          if (store_q) begin
            mem_wdata <= merged;
            mem_write <= 1'b1;
            state     <= S_WR;
          end else begin
            load_data <= ext_data;
            fault     <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_WR: begin
          load_data <= 32'd0;
          fault     <= 1'b0;
          done      <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_lsu
// Purpose  : Directed self-checking bench for mem_lsu with a one-word memory
//            model that registers read data on the mem_read edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        done;
  logic [31:0] load_data;
  logic        fault;

  int tests;
  int errors;

  logic [31:0] mem_word;
  int          rd_cnt;
  int          wr_cnt;
  int          acc_cnt;
  int          both_cnt;
  int          lat;

  localparam logic [31:0] BASE  = 32'h0010_0000;
  localparam logic [31:0] INIT  = 32'h8899_AABB;
  localparam logic [31:0] WIDX  = 32'h0004_0000;

  mem_lsu #(.ADDR_SHIFT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_store (req_store),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .done      (done),
    .load_data (load_data),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-word memory: registered read, write on strobe, plus activity counters
  always @(posedge clk) begin
    if (mem_read) begin
      mem_rdata <= mem_word;
      rd_cnt++;
    end
    if (mem_write) begin
      mem_word <= mem_wdata;
      wr_cnt++;
    end
    if (mem_read && mem_write)
      both_cnt++;
    if (req_valid && req_ready)
      acc_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Count falling edges until done is seen; 0 means it never arrived
  task automatic wait_done(output int n_out);
    n_out = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (done) begin
        n_out = n;
        break;
      end
    end
  endtask

  task automatic do_op(input logic st, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, output int n_out);
    @(negedge clk);
    rd_cnt    = 0;
    wr_cnt    = 0;
    req_valid = 1'b1;
    req_store = st;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 3'b111;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h5555_5555;
    wait_done(n_out);
  endtask

  initial begin
    tests     = 0;
    errors    = 0;
    rd_cnt    = 0;
    wr_cnt    = 0;
    acc_cnt   = 0;
    both_cnt  = 0;
    mem_word  = INIT;
    mem_rdata = 32'd0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_store = 1'b0;
    req_op    = 3'b000;
    req_addr  = 32'd0;
    req_wdata = 32'd0;

    #12;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_strobes", {29'd0, mem_read, mem_write, done}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Loads from word 0x8899AABB
    do_op(1'b0, 3'b000, BASE, 32'd0, lat);
    check("lb_lat", lat, 3);
    check("lb_data", load_data, 32'hFFFF_FF88);
    check("lb_reads", rd_cnt, 1);
    check("lb_fault", {31'd0, fault}, 32'd0);
    check("lb_mem_addr", mem_addr, WIDX);

    do_op(1'b0, 3'b100, BASE, 32'd0, lat);
    check("lbu_lat", lat, 3);
    check("lbu_data", load_data, 32'h0000_0088);

    do_op(1'b0, 3'b001, BASE + 32'd2, 32'd0, lat);
    check("lh_lat", lat, 3);
    check("lh_data", load_data, 32'hFFFF_AABB);

    do_op(1'b0, 3'b101, BASE, 32'd0, lat);
    check("lhu_data", load_data, 32'h0000_8899);

    do_op(1'b0, 3'b010, BASE, 32'd0, lat);
    check("lw_lat", lat, 3);
    check("lw_data", load_data, INIT);
    check("lw_reads", rd_cnt, 1);
    check("lw_writes", wr_cnt, 0);

    // Faults: done next cycle, no strobes, zero data
    do_op(1'b0, 3'b010, BASE + 32'd2, 32'd0, lat);
    check("flt_lw_lat", lat, 1);
    check("flt_lw_fault", {31'd0, fault}, 32'd1);
    check("flt_lw_data", load_data, 32'd0);
    check("flt_lw_strobes", rd_cnt + wr_cnt, 0);

    do_op(1'b0, 3'b001, BASE + 32'd1, 32'd0, lat);
    check("flt_lh_lat", lat, 1);
    check("flt_lh_fault", {31'd0, fault}, 32'd1);
    check("flt_lh_strobes", rd_cnt + wr_cnt, 0);

    do_op(1'b0, 3'b011, BASE, 32'd0, lat);
    check("flt_op3_lat", lat, 1);
    check("flt_op3_fault", {31'd0, fault}, 32'd1);
    check("flt_op3_strobes", rd_cnt + wr_cnt, 0);

    do_op(1'b1, 3'b100, BASE, 32'h1234_5678, lat);
    check("flt_st4_lat", lat, 1);
    check("flt_st4_fault", {31'd0, fault}, 32'd1);
    check("flt_st4_strobes", rd_cnt + wr_cnt, 0);
    check("flt_st4_mem", mem_word, INIT);

    // Sub-word stores via read-modify-write
    do_op(1'b1, 3'b000, BASE + 32'd1, 32'h1234_56EE, lat);
    check("sb_lat", lat, 4);
    check("sb_reads", rd_cnt, 1);
    check("sb_writes", wr_cnt, 1);
    check("sb_mem", mem_word, 32'h88EE_AABB);
    check("sb_fault", {31'd0, fault}, 32'd0);
    check("sb_load_data", load_data, 32'd0);

    mem_word = INIT;
    do_op(1'b1, 3'b001, BASE + 32'd2, 32'h0000_CAFE, lat);
    check("sh_lat", lat, 4);
    check("sh_mem", mem_word, 32'h8899_CAFE);

    mem_word = INIT;
    do_op(1'b1, 3'b010, BASE, 32'hDEAD_BEEF, lat);
    check("sw_lat", lat, 2);
    check("sw_reads", rd_cnt, 0);
    check("sw_writes", wr_cnt, 1);
    check("sw_mem", mem_word, 32'hDEAD_BEEF);

    // Held request during sb: second request only accepted back in IDLE
    @(negedge clk);
    mem_word  = INIT;
    acc_cnt   = 0;
    req_valid = 1'b1;
    req_store = 1'b1;
    req_op    = 3'b000;
    req_addr  = BASE + 32'd3;
    req_wdata = 32'h0000_00CC;
    @(posedge clk);
    #1;
    req_store = 1'b0;
    req_op    = 3'b010;
    req_addr  = BASE;
    req_wdata = 32'd0;
    wait_done(lat);
    check("b2b_sb_lat", lat, 4);
    check("b2b_sb_mem", mem_word, 32'h8899_AACC);
    check("b2b_one_accept", acc_cnt, 1);
    lat = 0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (acc_cnt == 2) begin
        lat = n;
        req_valid = 1'b0;
        break;
      end
    end
    check("b2b_reaccept_gap", lat, 2);
    wait_done(lat);
    check("b2b_lw_lat_rem", lat, 2);
    check("b2b_lw_data", load_data, 32'h8899_AACC);
    check("b2b_accepts", acc_cnt, 2);

    // Reset while the write strobe is high
    @(negedge clk);
    mem_word  = INIT;
    req_valid = 1'b1;
    req_store = 1'b1;
    req_op    = 3'b010;
    req_addr  = BASE;
    req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rw_write_hi", {31'd0, mem_write}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rw_write_drop", {31'd0, mem_write}, 32'd0);
    check("rw_ready", {31'd0, req_ready}, 32'd1);
    check("rw_flags", {29'd0, mem_read, done, fault}, 32'd0);
    check("rw_addr", mem_addr, 32'd0);
    check("rw_wdata", mem_wdata, 32'd0);
    check("rw_load_data", load_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("rw_mem_kept", mem_word, INIT);
    rst_n = 1'b1;
    @(negedge clk);

    check("never_rd_and_wr", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
`default_nettype wire
